game_controller: RTL and testbench
==================================

// Module: game_controller
// PURPOSE
//   Sequences one tic-tac-toe match from debounced, single-cycle move pulses.
//   Owns the board registers, whose turn it is, move validation, win/draw
//   detection, the per-game starting player and the saturating X/O scores.
//   Sits between the debouncer (move pulses, clear buttons) and the VGA board
//   renderer plus the seven-segment scoreboard, all on the 100 MHz clk domain.
// PARAMETERS
//   SCORE_MAX  9     score saturation value; scores are single BCD digits, 0..9
//   FIRST_X    1     1: X starts the first game after rst/clr_score; 0: O starts
// PORTS
//   clk        in   1  system clock; single clock domain
//   rst        in   1  synchronous, active-high reset
//   move_vld   in   1  one-cycle pulse: a cell was pressed
//   move_idx   in   4  pressed cell: 0..8 row-major (0 = top-left); 9..15 illegal
//   clr_board  in   1  one-cycle pulse: start a new game, keep scores
//   clr_score  in   1  one-cycle pulse: zero the scores and start a new game
//   move_rdy   out  1  high only in PLAY
//   x          out  9  cells held by X, bit n = cell n
//   o          out  9  cells held by O, bit n = cell n
//   turn       out  1  0 = X to move, 1 = O to move
//   inval_move out  1  one-cycle pulse: a move was rejected
//   x_win      out  1  level: X completed a line; held until the next clear
//   o_win      out  1  level: O completed a line; held until the next clear
//   draw       out  1  level: board full with no line; held until the next clear
//   x_score    out  4  X games won, BCD 0..SCORE_MAX
//   o_score    out  4  O games won, BCD 0..SCORE_MAX
// BEHAVIOUR
//   States: PLAY, CHECK, OVER. All outputs are registered.
//   rst: state=PLAY; x=o=0; flags=0; move_cnt=0; scores=0; turn=starter=~FIRST_X.
//   Priority within one cycle: rst > clr_score > clr_board > move_vld.
//   PLAY, move_vld=1:
//     - Reject when move_idx>8 or x[idx]|o[idx]. Next cycle inval_move=1 for one
//       cycle. Board, turn and state are unchanged.
//     - Accept otherwise. Next cycle the mover's bit idx is set, turn toggles,
//       move_cnt increments and state=CHECK.
//   CHECK (exactly 1 cycle): evaluate all 8 lines on the registered board.
//     - X line: x_win=1, x_score+=1 (saturating at SCORE_MAX), go to OVER.
//     - Else O line: the same for O.
//     - Else move_cnt==9: draw=1, go to OVER. Else go to PLAY.
//     - move_vld during CHECK or OVER: dropped, inval_move=1 for one cycle,
//       nothing else changes.
//   Result flags are visible 2 cycles after the winning move_vld. At most one of
//   x_win/o_win/draw is ever 1.
//   clr_board (any state): the next cycle has state=PLAY, x=o=0, all flags=0 and
//   move_cnt=0. starter toggles and turn loads the new starter, so the starting
//   player alternates per game. A clear during CHECK discards the pending
//   evaluation: no score change.
//   clr_score (any state): everything clr_board does, plus both scores=0 and
//   starter/turn=~FIRST_X (no toggle).
//   move_cnt is 4 bits, 0..9, and never wraps: the board is full at 9.
// STRUCTURE
//   Package ttt_pkg:
//     - state enum
//     - CELLS=9
//     - WIN_LINES[8][3] cell-index table
//     - BCD digit width
//   Sub-module line_detect: combinational, board[8:0] -> line_hit. It is
//   instantiated twice, once for x and once for o.
//   The controller holds the FSM, board, turn/starter, move_cnt and the
//   saturating score counters.
// TESTING
//   1. rst, then moves 0,3,1,4,2 -> x=9'h007, o=9'h018, x_win=1 2 cycles after
//      the last move_vld, x_score=1, move_rdy=0.
//   2. Move 4, then move 4 again -> second move gives inval_move=1 for 1 cycle,
//      turn stays 1, o=0.
//   3. move_idx=12 in PLAY -> inval_move pulse, board unchanged. Any move in OVER
//      -> inval_move pulse, scores unchanged.
//   4. Moves 0,4,8,1,7,6,2,5,3 -> draw=1, x_win=o_win=0, scores unchanged,
//      move_cnt=9.
//   5. Win 10 games as X using clr_board between games -> x_score stays 9. The
//      starter alternates X,O,X... after each clr_board.
//   6. clr_score and clr_board in the same cycle as a winning move_vld -> board
//      cleared, scores 0, turn=0, no win flag. rst mid-game -> all outputs at
//      reset values the next cycle.

Source files
------------

// File: rtl/ttt_pkg.sv
// rtl/ttt_pkg.sv - shared types and constants for the tic-tac-toe controller
package ttt_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    CHECK = 2'd1,
    OVER  = 2'd2
  } state_t;

  localparam int CELLS   = 9;
  localparam int N_LINES = 8;
  localparam int BCD_W   = 4;

  // Rows, then columns, then the two diagonals; cells are row-major, 0 = top-left.
  localparam logic [3:0] WIN_LINES [N_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

endpackage

// File: rtl/line_detect.sv
// rtl/line_detect.sv - flags a completed line in one player's board
module line_detect
  import ttt_pkg::*;
(
  input  logic [CELLS-1:0] board,
  output logic             line_hit
);

  // OR together the three-cell AND of every winning line.
  always_comb begin
    line_hit = 1'b0;
    for (int i = 0; i < N_LINES; i++) begin
      line_hit = line_hit |
                 (board[WIN_LINES[i][0]] & board[WIN_LINES[i][1]] & board[WIN_LINES[i][2]]);
    end
  end

endmodule

// File: rtl/game_controller.sv
// rtl/game_controller.sv - tic-tac-toe match sequencer with board, turn and scores
module game_controller
  import ttt_pkg::*;
#(
  parameter logic [BCD_W-1:0] SCORE_MAX = 4'd9,
  parameter bit               FIRST_X   = 1'b1
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             move_vld,
  input  logic [3:0]       move_idx,
  input  logic             clr_board,
  input  logic             clr_score,
  output logic             move_rdy,
  output logic [CELLS-1:0] x,
  output logic [CELLS-1:0] o,
  output logic             turn,
  output logic             inval_move,
  output logic             x_win,
  output logic             o_win,
  output logic             draw,
  output logic [BCD_W-1:0] x_score,
  output logic [BCD_W-1:0] o_score
);

  state_t             state, state_d;
  logic [CELLS-1:0]   x_d, o_d;
  logic               turn_d, starter, starter_d;
  logic [3:0]         move_cnt, move_cnt_d;
  logic [BCD_W-1:0]   x_score_d, o_score_d;
  logic               x_win_d, o_win_d, draw_d, inval_d, move_rdy_d;
  logic               x_hit, o_hit;
  logic [CELLS-1:0]   cell_bit;
  logic               occupied;

  line_detect u_x_line (.board(x), .line_hit(x_hit));
  line_detect u_o_line (.board(o), .line_hit(o_hit));

  assign cell_bit = 9'(1) << move_idx;
  assign occupied = |((x | o) & cell_bit);

  // Next-state and next-output logic; clears override any move or evaluation.
  always_comb begin
    state_d    = state;
    x_d        = x;
    o_d        = o;
    turn_d     = turn;
    starter_d  = starter;
    move_cnt_d = move_cnt;
    x_score_d  = x_score;
    o_score_d  = o_score;
    x_win_d    = x_win;
    o_win_d    = o_win;
    draw_d     = draw;
    inval_d    = 1'b0;

    if (clr_score || clr_board) begin
      state_d    = PLAY;
      x_d        = '0;
      o_d        = '0;
      move_cnt_d = 4'd0;
      x_win_d    = 1'b0;
      o_win_d    = 1'b0;
      draw_d     = 1'b0;
      if (clr_score) begin
        x_score_d = '0;
        o_score_d = '0;
        starter_d = ~FIRST_X;
        turn_d    = ~FIRST_X;
      end else begin
        starter_d = ~starter;
        turn_d    = ~starter;
      end
    end else begin
      unique case (state)
        PLAY: begin
          if (move_vld) begin
            if (move_idx > 4'd8 || occupied) begin
              inval_d = 1'b1;
            end else begin
              if (turn) o_d = o | cell_bit;
              else      x_d = x | cell_bit;
              turn_d     = ~turn;
              move_cnt_d = move_cnt + 4'd1;
              state_d    = CHECK;
            end
          end
        end
        CHECK: begin
          inval_d = move_vld;
          if (x_hit) begin
            x_win_d = 1'b1;
            if (x_score < SCORE_MAX) x_score_d = x_score + 4'd1;
            state_d = OVER;
          end else if (o_hit) begin
            o_win_d = 1'b1;
            if (o_score < SCORE_MAX) o_score_d = o_score + 4'd1;
            state_d = OVER;
          end else if (move_cnt == 4'd9) begin
            draw_d  = 1'b1;
            state_d = OVER;
          end else begin
            state_d = PLAY;
          end
        end
        OVER: begin
          inval_d = move_vld;
        end
        default: state_d = PLAY;
      endcase
    end

    move_rdy_d = (state_d == PLAY);
  end

  // Register the FSM state and every output so downstream sees glitch-free levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PLAY;
      x          <= '0;
      o          <= '0;
      turn       <= ~FIRST_X;
      starter    <= ~FIRST_X;
      move_cnt   <= 4'd0;
      x_score    <= '0;
      o_score    <= '0;
      x_win      <= 1'b0;
      o_win      <= 1'b0;
      draw       <= 1'b0;
      inval_move <= 1'b0;
      move_rdy   <= 1'b1;
    end else begin
      state      <= state_d;
      x          <= x_d;
      o          <= o_d;
      turn       <= turn_d;
      starter    <= starter_d;
      move_cnt   <= move_cnt_d;
      x_score    <= x_score_d;
      o_score    <= o_score_d;
      x_win      <= x_win_d;
      o_win      <= o_win_d;
      draw       <= draw_d;
      inval_move <= inval_d;
      move_rdy   <= move_rdy_d;
    end
  end

endmodule

// File: tb/tb_game_controller.sv
// tb/tb_game_controller.sv - directed self-checking bench for game_controller
module tb_game_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       move_vld;
  logic [3:0] move_idx;
  logic       clr_board;
  logic       clr_score;
  logic       move_rdy;
  logic [8:0] x;
  logic [8:0] o;
  logic       turn;
  logic       inval_move;
  logic       x_win;
  logic       o_win;
  logic       draw;
  logic [3:0] x_score;
  logic [3:0] o_score;

  int n_tests = 0;
  int n_fail  = 0;
  logic exp_starter;

  game_controller dut (
    .clk        (clk),
    .rst        (rst),
    .move_vld   (move_vld),
    .move_idx   (move_idx),
    .clr_board  (clr_board),
    .clr_score  (clr_score),
    .move_rdy   (move_rdy),
    .x          (x),
    .o          (o),
    .turn       (turn),
    .inval_move (inval_move),
    .x_win      (x_win),
    .o_win      (o_win),
    .draw       (draw),
    .x_score    (x_score),
    .o_score    (o_score)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_move(input logic [3:0] idx);
    move_idx = idx;
    move_vld = 1'b1;
    tick();
    move_vld = 1'b0;
  endtask

  task automatic play(input logic [3:0] idx);
    do_move(idx);
    tick();
  endtask

  task automatic pulse_clr_board();
    clr_board = 1'b1;
    tick();
    clr_board = 1'b0;
    exp_starter = ~exp_starter;
  endtask

  task automatic pulse_clr_score();
    clr_score = 1'b1;
    tick();
    clr_score = 1'b0;
    exp_starter = 1'b0;
  endtask

  // Plays every move of an X win except X's final move on cell 2.
  task automatic x_game_setup();
    if (exp_starter == 1'b0) begin
      play(0); play(3); play(1); play(4);
    end else begin
      play(3); play(0); play(4); play(1); play(6);
    end
  endtask

  initial begin
    rst = 1'b1; move_vld = 1'b0; move_idx = 4'd0;
    clr_board = 1'b0; clr_score = 1'b0;
    exp_starter = 1'b0;
    tick(); tick();
    rst = 1'b0;

    check("rst_x", x, 9'h000);
    check("rst_o", o, 9'h000);
    check("rst_turn", turn, 1'b0);
    check("rst_rdy", move_rdy, 1'b1);
    check("rst_flags", {x_win, o_win, draw, inval_move}, 4'b0000);
    check("rst_scores", {x_score, o_score}, 8'h00);

    // 1: X wins on top row
    play(0); play(3); play(1); play(4);
    do_move(2);
    check("t1_check_rdy", move_rdy, 1'b0);
    check("t1_check_x", x, 9'h007);
    check("t1_nowin_yet", x_win, 1'b0);
    tick();
    check("t1_x", x, 9'h007);
    check("t1_o", o, 9'h018);
    check("t1_xwin", x_win, 1'b1);
    check("t1_xscore", x_score, 4'd1);
    check("t1_rdy", move_rdy, 1'b0);
    check("t1_other_flags", {o_win, draw}, 2'b00);

    // 3b: a move in OVER is rejected and scores stay put
    do_move(5);
    check("t3_over_inval", inval_move, 1'b1);
    check("t3_over_x", x, 9'h007);
    check("t3_over_score", {x_score, o_score}, 8'h10);
    tick();
    check("t3_over_inval_drop", inval_move, 1'b0);

    // 2: repeated cell is rejected
    pulse_clr_score();
    check("t2_clr_scores", {x_score, o_score}, 8'h00);
    check("t2_clr_turn", turn, 1'b0);
    check("t2_clr_board", {x, o}, 18'h0);
    play(4);
    do_move(4);
    check("t2_inval", inval_move, 1'b1);
    check("t2_turn", turn, 1'b1);
    check("t2_o", o, 9'h000);
    check("t2_x", x, 9'h010);
    tick();
    check("t2_inval_drop", inval_move, 1'b0);

    // 3a: out-of-range index
    do_move(12);
    check("t3_idx_inval", inval_move, 1'b1);
    check("t3_idx_board", {x, o}, {9'h010, 9'h000});
    check("t3_idx_rdy", move_rdy, 1'b1);
    check("t3_idx_turn", turn, 1'b1);
    tick();

    // 4: full board without a line
    pulse_clr_score();
    play(0); play(4); play(8); play(1); play(7); play(6); play(2); play(5);
    do_move(3);
    tick();
    check("t4_draw", draw, 1'b1);
    check("t4_wins", {x_win, o_win}, 2'b00);
    check("t4_x", x, 9'h18D);
    check("t4_o", o, 9'h072);
    check("t4_scores", {x_score, o_score}, 8'h00);
    check("t4_move_cnt", dut.move_cnt, 4'd9);
    check("t4_rdy", move_rdy, 1'b0);

    // 5: ten X wins, starter alternating, score saturating at 9
    for (int g = 0; g < 10; g++) begin
      pulse_clr_board();
      check($sformatf("t5_starter_%0d", g), turn, exp_starter);
      check($sformatf("t5_clr_flags_%0d", g), {x_win, o_win, draw}, 3'b000);
      x_game_setup();
      do_move(2);
      tick();
      check($sformatf("t5_xwin_%0d", g), x_win, 1'b1);
      check($sformatf("t5_xscore_%0d", g), x_score, (g + 1 > 9) ? 4'd9 : 4'(g + 1));
    end

    // clr_board during CHECK drops the pending win
    pulse_clr_board();
    x_game_setup();
    do_move(2);
    clr_board = 1'b1;
    tick();
    clr_board = 1'b0;
    exp_starter = ~exp_starter;
    tick();
    check("t6_chk_clr_xwin", x_win, 1'b0);
    check("t6_chk_clr_score", x_score, 4'd9);
    check("t6_chk_clr_board", {x, o}, 18'h0);

    // 6: both clears with a winning move in the same cycle
    x_game_setup();
    move_idx = 4'd2; move_vld = 1'b1; clr_board = 1'b1; clr_score = 1'b1;
    tick();
    move_vld = 1'b0; clr_board = 1'b0; clr_score = 1'b0;
    exp_starter = 1'b0;
    check("t6_board", {x, o}, 18'h0);
    check("t6_scores", {x_score, o_score}, 8'h00);
    check("t6_turn", turn, 1'b0);
    check("t6_rdy", move_rdy, 1'b1);
    check("t6_inval", inval_move, 1'b0);
    tick();
    check("t6_no_win", {x_win, o_win, draw}, 3'b000);

    // O win
    play(0); play(3); play(1); play(4); play(8);
    do_move(5);
    tick();
    check("t7_owin", o_win, 1'b1);
    check("t7_xwin", x_win, 1'b0);
    check("t7_oscore", o_score, 4'd1);
    check("t7_o", o, 9'h038);

    // rst mid-game
    pulse_clr_board();
    play(0); play(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t8_board", {x, o}, 18'h0);
    check("t8_scores", {x_score, o_score}, 8'h00);
    check("t8_turn", turn, 1'b0);
    check("t8_flags", {x_win, o_win, draw, inval_move}, 4'b0000);
    check("t8_rdy", move_rdy, 1'b1);
    check("t8_move_cnt", dut.move_cnt, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
